// File: rtl/rs232_rx_fifo.sv
// Receive FIFO between the rs232in deserialiser and the register block, with nrts hysteresis.
// Optional two-flop ncts synchroniser driving tx_hold: define RS232_RX_CTS_SYNC_EN.
module rs232_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_HIGH   = 12,
    parameter int RTS_LOW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          in_data,
    input  logic                in_attention,
    input  logic                rd,
    output logic [7:0]          rd_data,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count,
    output logic                overflow,
    input  logic                clr_overflow,
    output logic                nrts,
    input  logic                ncts,
    output logic                tx_hold
);

    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] HIGH_CNT = CW'(RTS_HIGH);
    localparam logic [CW-1:0] LOW_CNT  = CW'(RTS_LOW);

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  nrts_q, nrts_d;

    logic full;
    logic is_empty;
    logic push;
    logic pop;
    logic drop;

    // A push into a full FIFO is only legal when the same edge pops a slot free.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        full     = (count_q == FULL_CNT);
        is_empty = (count_q == '0);
        pop      = rd && !is_empty;
        push     = in_attention && (!full || pop);
        drop     = in_attention && full && !rd;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        nrts_d     = nrts_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A coinciding drop beats the clear so no overflow event is ever lost.
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;

        // Hysteresis on the next-state count so nrts moves on the same edge as count.
        if (count_d >= HIGH_CNT)     nrts_d = 1'b1;
        else if (count_d <= LOW_CNT) nrts_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            nrts_q     <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            nrts_q     <= nrts_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= in_data;
    end

    always_comb begin
        rd_data  = is_empty ? 8'h00 : mem_q[rd_ptr_q];
        empty    = is_empty;
        count    = count_q;
        overflow = overflow_q;
        nrts     = nrts_q;
    end

`ifdef RS232_RX_CTS_SYNC_EN
    logic cts_meta_q, cts_meta_d;
    logic cts_sync_q, cts_sync_d;

    always_comb begin
        cts_meta_d = ncts;
        cts_sync_d = cts_meta_q;
    end

    // Both stages reset high so the transmitter is held until the remote is seen ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_meta_d;
            cts_sync_q <= cts_sync_d;
        end
    end

    assign tx_hold = cts_sync_q;
`else
    logic unused_ncts;
    assign unused_ncts = ncts;
    assign tx_hold     = 1'b0;
`endif

endmodule

// File: doc/rs232_rx_fifo.md
Name: rs232_rx_fifo

Overview:
Receive-side buffer between the rs232in deserialiser and the rs232 peripheral register block. Captures each received byte on the attention strobe into a small FIFO and presents the head byte, occupancy count and a sticky overflow flag to the CPU-visible register logic. Drives the board's ser_nrts line with hysteresis so the remote sender is throttled before the FIFO fills.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 by default)
RTS_HIGH, 12, occupancy at or above which nrts is deasserted (driven 1)
RTS_LOW, 4, occupancy at or below which nrts is reasserted (driven 0); must be < RTS_HIGH

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_data  in  8  received byte from rs232in
in_attention  in  1  one-cycle strobe: in_data valid
rd  in  1  pop strobe from register block
rd_data  out  8  head byte; 0 when empty
empty  out  1  FIFO empty
count  out  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
overflow  out  1  sticky: a byte was dropped because the FIFO was full
clr_overflow  in  1  clears overflow
nrts  out  1  active-low request-to-send to remote sender
ncts  in  1  active-low clear-to-send from remote (used only with optional feature)
tx_hold  out  1  tells transmitter to hold off

Behaviour:
- Clocking/reset: one clock, clk; rst is synchronous and active-high. While rst=1 at a clock edge: rd_ptr=wr_ptr=0, count=0, empty=1, rd_data=0, overflow=0, nrts=1, tx_hold=0. Storage array is not reset.
- nrts=1 in reset; the first edge with rst=0 sets nrts=0 (count=0 <= RTS_LOW).
- Storage: 2^DEPTH_LOG2 x 8 array; pointers DEPTH_LOG2 bits, wrap modulo depth. Full is count == 2^DEPTH_LOG2.
- rd_data = mem[rd_ptr] combinationally when !empty, else 0 (first-word-fall-through). empty = (count == 0), derived from registered count.
- Push: in_attention=1 and (not full, or rd=1 with count>0 in same cycle) -> mem[wr_ptr]<=in_data, wr_ptr++ at that edge.
- Pop: rd=1 and !empty -> rd_ptr++ at that edge; rd while empty is ignored (no pointer/count change, no error).
- Count: +1 push only, -1 pop only, unchanged for push+pop or neither. Push and pop same cycle when full: both accepted, no overflow. Push and pop same cycle when empty: push accepted, pop ignored, count becomes 1.
- Overflow: in_attention=1, full, rd=0 -> byte dropped, overflow<=1, pointers/count unchanged. clr_overflow=1 clears overflow; if a drop and clr_overflow coincide, set wins (overflow=1).
- Latency: byte strobed at edge N is visible on rd_data, count, empty after edge N (one cycle).
- Flow control, evaluated on the next-state count: next_count >= RTS_HIGH -> nrts<=1; next_count <= RTS_LOW -> nrts<=0; otherwise hold. nrts is registered, so it changes on the same edge as count.
- Reset mid-operation: all content discarded, state as above; an in_attention in the reset cycle is dropped and does not set overflow.

Optional Feature:
Macro RS232_RX_CTS_SYNC_EN.
- Defined: ncts passes through a two-flop synchroniser (both flops reset to 1); tx_hold = synchronised ncts, so tx_hold follows an ncts change 2 cycles later. tx_hold resets to 1 and reads 0 two cycles after rst drops if ncts=0.
- Undefined: ncts unused; tx_hold is constant 0.

Test Plan:
- Reset then idle: after rst low for 1 cycle -> count=0, empty=1, rd_data=0, overflow=0, nrts=0.
- Push 0x41,0x42,0x43 on separate cycles, then pop 3 times -> rd_data 0x41,0x42,0x43 in order; count 3->0; empty=1 afterwards.
- Push 17 bytes 0x00..0x10 without popping -> count=16, overflow=1, byte 0x10 dropped; nrts went 1 on the push that made count=12; drain all 16 -> rd_data 0x00..0x0F; nrts returns 0 on the pop that made count=4.
- Full FIFO, simultaneous in_attention(0xAA)+rd -> count stays 16, overflow stays 0; 0xAA appears last after draining. Empty FIFO, simultaneous push(0x55)+rd -> count=1, rd_data=0x55.
- overflow=1 with clr_overflow and a dropping push in the same cycle -> overflow stays 1; clr_overflow alone next cycle -> 0. rst asserted with count=7 -> count=0, nrts=1 during reset.
- With RS232_RX_CTS_SYNC_EN: ncts 1->0 at edge N -> tx_hold=0 after edge N+2; without the macro, tx_hold=0 regardless of ncts.
